traffic_intersection_controller: RTL and testbench
==================================================

TRAFFIC_INTERSECTION_CONTROLLER -- requirements
Module: traffic_intersection_controller

Interface
REQ-001 SHALL have parameter GREEN_TIME, default 5, giving green dwell in clock cycles (>=1).
REQ-002 SHALL have parameter YELLOW_TIME, default 2, giving yellow dwell in cycles (>=1).
REQ-003 SHALL have parameter ALL_RED_TIME, default 1, giving all-red clearance dwell in cycles (>=1).
REQ-004 SHALL have parameter WALK_TIME, default 3, giving pedestrian walk dwell in cycles (>=1).
REQ-005 SHALL have parameter CNT_W, default 8, giving dwell counter width; each *_TIME SHALL be < 2**CNT_W.
REQ-006 SHALL have port clk  input  1  system clock, rising edge active.
REQ-007 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have port ped_req  input  1  pedestrian request; single-cycle pulse or level.
REQ-009 SHALL have port emerg  input  1  emergency override request, level.
REQ-010 SHALL have ports ns_red, ns_yellow, ns_green  output  1 each  north-south lamps.
REQ-011 SHALL have ports ew_red, ew_yellow, ew_green  output  1 each  east-west lamps.
REQ-012 SHALL have port walk  output  1  pedestrian walk lamp.
REQ-013 SHALL have port ped_pending  output  1  a pedestrian request is latched and not yet served.

Function
REQ-014 SHALL implement states CLR (all-red clearance), NS_G, NS_Y, EW_G, EW_Y, WALK and EMERG.
REQ-015 SHALL drive outputs as a Moore decode of the state register: exactly one lamp per direction lit; red lit in CLR, WALK and EMERG; walk=1 only in WALK.
REQ-016 SHALL clear the dwell counter to 0 on every state entry; a timed state SHALL last exactly its *_TIME cycles, leaving when counter == TIME-1.
REQ-017 SHALL sequence normally NS_G -> NS_Y -> CLR -> EW_G -> EW_Y -> CLR -> NS_G, using a next_dir flag toggled on each yellow exit.
REQ-018 SHALL set ped_pending on any cycle ped_req=1 and clear it on entry to WALK; a ped_req in the entry cycle of WALK SHALL NOT be lost (set wins).
REQ-019 SHALL, on CLR expiry with ped_pending=1 and emerg=0, go to WALK; WALK expiry SHALL go to CLR and then the green given by next_dir.
REQ-020 SHALL, when emerg=1 in a green state, go to that direction's yellow on the next edge, truncating green.
REQ-021 SHALL complete a yellow normally when emerg=1, then enter CLR; CLR expiry with emerg=1 SHALL go to EMERG.
REQ-022 SHALL, when emerg=1 in WALK, go to EMERG on the next edge (walk dropped immediately).
REQ-023 SHALL hold EMERG while emerg=1; on emerg=0 SHALL go to CLR, then resume with next_dir unchanged (pending ped served first).
REQ-024 SHALL apply priority at any decision point: emerg > ped_pending > normal sequence.

Reset
REQ-025 SHALL, on rst=1, asynchronously enter CLR with counter=0, next_dir=NS, ped_pending=0.
REQ-026 SHALL during and immediately after reset drive ns_red=ew_red=1, all other outputs 0.
REQ-027 SHALL, on reset mid-operation (any state), abandon the state without completing dwell.

Structure
REQ-028 SHALL place the state enumeration and direction encoding (NS=0, EW=1) in a shared package traffic_pkg.
REQ-029 SHALL use one sub-module dwell_timer (load-on-entry counter, expiry flag), parameterised by CNT_W.

Verification (GREEN=5, YELLOW=2, ALL_RED=1, WALK=3)
REQ-030 SHALL check: rst released at edge 0, no inputs -> CLR 1 cycle, NS_G 5, NS_Y 2, CLR 1, EW_G 5, EW_Y 2, repeat; 16-cycle period.
REQ-031 SHALL check: ped_req pulse in 2nd NS_G cycle -> ped_pending=1 next edge; after NS_Y and CLR, walk=1 for exactly 3 cycles, ped_pending=0, then CLR, EW_G.
REQ-032 SHALL check: emerg=1 in 1st NS_G cycle -> NS_Y next edge for 2 cycles, CLR 1, EMERG held 10 cycles; emerg=0 -> CLR 1, EW_G.
REQ-033 SHALL check: emerg=1 in 2nd WALK cycle -> walk=0 next edge, state EMERG.
REQ-034 SHALL check: rst=1 asynchronously mid EW_G -> ns_red=ew_red=1 before next clk edge, all other lamps 0, ped_pending=0.
REQ-035 SHALL check: at every cycle, never both directions non-red and never walk=1 with any green.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types for the traffic intersection controller: FSM states, direction
// encoding and the lamp bundle with its Moore decode.
package traffic_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned LAMP_W  = 7;

  typedef enum logic [STATE_W-1:0] {
    ST_CLR   = 3'd0,
    ST_NS_G  = 3'd1,
    ST_NS_Y  = 3'd2,
    ST_EW_G  = 3'd3,
    ST_EW_Y  = 3'd4,
    ST_WALK  = 3'd5,
    ST_EMERG = 3'd6
  } state_e;

  typedef enum logic {
    DIR_NS = 1'b0,
    DIR_EW = 1'b1
  } dir_e;

  typedef struct packed {
    logic ns_red;
    logic ns_yellow;
    logic ns_green;
    logic ew_red;
    logic ew_yellow;
    logic ew_green;
    logic walk;
  } lamps_t;

  localparam lamps_t LAMPS_ALL_RED = 7'b100_100_0;

  // One lamp per direction; red unless that direction is green or yellow.
  function automatic lamps_t lamps_decode(input state_e st);
    lamps_t l;
    l = LAMPS_ALL_RED;
    case (st)
      ST_NS_G: begin l.ns_red = 1'b0; l.ns_green  = 1'b1; end
      ST_NS_Y: begin l.ns_red = 1'b0; l.ns_yellow = 1'b1; end
      ST_EW_G: begin l.ew_red = 1'b0; l.ew_green  = 1'b1; end
      ST_EW_Y: begin l.ew_red = 1'b0; l.ew_yellow = 1'b1; end
      ST_WALK: l.walk = 1'b1;
      default: l = LAMPS_ALL_RED;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Dwell counter: cleared on state entry, counts up (saturating), and flags
// expiry in the last cycle of a dwell of 'limit' cycles.
module dwell_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] limit,
  output logic             expired_c
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (cnt_q != {CNT_W{1'b1}}) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_c = (cnt_q == (limit - CNT_W'(1)));

endmodule

// File: rtl/traffic_intersection_controller.sv
// Two-direction intersection controller with all-red clearance, pedestrian
// walk phase and emergency override; lamps are a registered Moore decode.
module traffic_intersection_controller
  import traffic_pkg::*;
#(
  parameter int unsigned GREEN_TIME   = 5,
  parameter int unsigned YELLOW_TIME  = 2,
  parameter int unsigned ALL_RED_TIME = 1,
  parameter int unsigned WALK_TIME    = 3,
  parameter int unsigned CNT_W        = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic ped_req,
  input  logic emerg,
  output logic ns_red,
  output logic ns_yellow,
  output logic ns_green,
  output logic ew_red,
  output logic ew_yellow,
  output logic ew_green,
  output logic walk,
  output logic ped_pending
);

  state_e           state_q, state_d;
  dir_e             next_dir_q, next_dir_d;
  logic             ped_pending_q, ped_pending_d;
  lamps_t           lamps_q, lamps_d;
  logic [CNT_W-1:0] dwell_limit;
  logic             dwell_load;
  logic             dwell_done_c;

  dwell_timer #(
    .CNT_W (CNT_W)
  ) u_dwell_timer (
    .clk       (clk),
    .rst       (rst),
    .load      (dwell_load),
    .limit     (dwell_limit),
    .expired_c (dwell_done_c)
  );

  // Dwell length of the current state; EMERG is untimed.
  always_comb begin
    dwell_limit = {CNT_W{1'b1}};
    case (state_q)
      ST_CLR:  dwell_limit = CNT_W'(ALL_RED_TIME);
      ST_NS_G: dwell_limit = CNT_W'(GREEN_TIME);
      ST_EW_G: dwell_limit = CNT_W'(GREEN_TIME);
      ST_NS_Y: dwell_limit = CNT_W'(YELLOW_TIME);
      ST_EW_Y: dwell_limit = CNT_W'(YELLOW_TIME);
      ST_WALK: dwell_limit = CNT_W'(WALK_TIME);
      default: dwell_limit = {CNT_W{1'b1}};
    endcase
  end

  // Next state: emergency beats pedestrian beats the normal rotation.
  always_comb begin
    state_d    = state_q;
    next_dir_d = next_dir_q;
    case (state_q)
      ST_CLR: begin
        if (dwell_done_c) begin
          if (emerg) begin
            state_d = ST_EMERG;
          end else if (ped_pending_q) begin
            state_d = ST_WALK;
          end else begin
            state_d = (next_dir_q == DIR_NS) ? ST_NS_G : ST_EW_G;
          end
        end
      end
      ST_NS_G: if (emerg || dwell_done_c) state_d = ST_NS_Y;
      ST_EW_G: if (emerg || dwell_done_c) state_d = ST_EW_Y;
      ST_NS_Y: begin
        if (dwell_done_c) begin
          state_d    = ST_CLR;
          next_dir_d = DIR_EW;
        end
      end
      ST_EW_Y: begin
        if (dwell_done_c) begin
          state_d    = ST_CLR;
          next_dir_d = DIR_NS;
        end
      end
      ST_WALK: begin
        if (emerg) begin
          state_d = ST_EMERG;
        end else if (dwell_done_c) begin
          state_d = ST_CLR;
        end
      end
      ST_EMERG: if (!emerg) state_d = ST_CLR;
      default:  state_d = ST_CLR;
    endcase
  end

  // A request arriving on the cycle WALK is entered stays latched.
  always_comb begin
    ped_pending_d = ped_pending_q;
    if ((state_d == ST_WALK) && (state_q != ST_WALK)) begin
      ped_pending_d = 1'b0;
    end
    if (ped_req) begin
      ped_pending_d = 1'b1;
    end
  end

  assign dwell_load = (state_d != state_q);
  assign lamps_d    = lamps_decode(state_d);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_CLR;
      next_dir_q    <= DIR_NS;
      ped_pending_q <= 1'b0;
      lamps_q       <= LAMPS_ALL_RED;
    end else begin
      state_q       <= state_d;
      next_dir_q    <= next_dir_d;
      ped_pending_q <= ped_pending_d;
      lamps_q       <= lamps_d;
    end
  end

  assign ns_red      = lamps_q.ns_red;
  assign ns_yellow   = lamps_q.ns_yellow;
  assign ns_green    = lamps_q.ns_green;
  assign ew_red      = lamps_q.ew_red;
  assign ew_yellow   = lamps_q.ew_yellow;
  assign ew_green    = lamps_q.ew_green;
  assign walk        = lamps_q.walk;
  assign ped_pending = ped_pending_q;

endmodule

// File: tb/tb_traffic_intersection_controller.sv
// Bench for traffic_intersection_controller: phase-level reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_traffic_intersection_controller;

  localparam int GREEN   = 5;
  localparam int YELLOW  = 2;
  localparam int ALL_RED = 1;
  localparam int WALKT   = 3;

  localparam int P_CLR = 0, P_NSG = 1, P_NSY = 2, P_EWG = 3, P_EWY = 4, P_WALK = 5, P_EMG = 6;

  // {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, walk}
  localparam logic [6:0] L_ALLRED = 7'b100_100_0;
  localparam logic [6:0] L_NSG    = 7'b001_100_0;
  localparam logic [6:0] L_NSY    = 7'b010_100_0;
  localparam logic [6:0] L_EWG    = 7'b100_001_0;
  localparam logic [6:0] L_EWY    = 7'b100_010_0;
  localparam logic [6:0] L_WALK   = 7'b100_100_1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ped_req = 1'b0;
  logic emerg = 1'b0;
  logic ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk, ped_pending;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  traffic_intersection_controller #(
    .GREEN_TIME   (GREEN),
    .YELLOW_TIME  (YELLOW),
    .ALL_RED_TIME (ALL_RED),
    .WALK_TIME    (WALKT),
    .CNT_W        (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ped_req     (ped_req),
    .emerg       (emerg),
    .ns_red      (ns_red),
    .ns_yellow   (ns_yellow),
    .ns_green    (ns_green),
    .ew_red      (ew_red),
    .ew_yellow   (ew_yellow),
    .ew_green    (ew_green),
    .walk        (walk),
    .ped_pending (ped_pending)
  );

  always #5 clk = ~clk;

  wire [6:0] dut_lamps = {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at t=%0t cyc=%0d: got %0h expected %0h", name, $time, cyc, act, exp);
    end
  endtask

  // Reference model: phase plus cycles remaining in that phase.
  int m_ph = P_CLR;
  int m_left = ALL_RED;
  bit m_dir_ew = 1'b0;
  bit m_ped = 1'b0;
  int m_nph;

  function automatic int dwell_of(input int ph);
    case (ph)
      P_CLR:         return ALL_RED;
      P_NSG, P_EWG:  return GREEN;
      P_NSY, P_EWY:  return YELLOW;
      P_WALK:        return WALKT;
      default:       return 0;
    endcase
  endfunction

  function automatic int next_phase(input int ph, input int left, input bit dir_ew,
                                    input bit ped, input bit em);
    case (ph)
      P_CLR:  if (left == 1) return em ? P_EMG : (ped ? P_WALK : (dir_ew ? P_EWG : P_NSG));
      P_NSG:  if (em || left == 1) return P_NSY;
      P_EWG:  if (em || left == 1) return P_EWY;
      P_NSY:  if (left == 1) return P_CLR;
      P_EWY:  if (left == 1) return P_CLR;
      P_WALK: begin
        if (em) return P_EMG;
        if (left == 1) return P_CLR;
      end
      P_EMG:  if (!em) return P_CLR;
      default: return P_CLR;
    endcase
    return ph;
  endfunction

  function automatic logic [6:0] lamps_of(input int ph);
    case (ph)
      P_NSG:  return L_NSG;
      P_NSY:  return L_NSY;
      P_EWG:  return L_EWG;
      P_EWY:  return L_EWY;
      P_WALK: return L_WALK;
      default: return L_ALLRED;
    endcase
  endfunction

  always_comb m_nph = next_phase(m_ph, m_left, m_dir_ew, m_ped, emerg);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ph     <= P_CLR;
      m_left   <= ALL_RED;
      m_dir_ew <= 1'b0;
      m_ped    <= 1'b0;
    end else begin
      m_ph <= m_nph;
      if (m_nph != m_ph) begin
        m_left <= dwell_of(m_nph);
        m_ped  <= (m_nph == P_WALK) ? ped_req : (m_ped | ped_req);
      end else begin
        m_left <= m_left - 1;
        m_ped  <= m_ped | ped_req;
      end
      if (m_ph == P_NSY && m_nph == P_CLR) m_dir_ew <= 1'b1;
      if (m_ph == P_EWY && m_nph == P_CLR) m_dir_ew <= 1'b0;
    end
  end

  // Every-cycle comparison against the model plus safety invariants.
  always @(negedge clk) begin
    check("model_lamps", 32'(dut_lamps), 32'(lamps_of(m_ph)));
    check("model_ped_pending", 32'(ped_pending), 32'(m_ped));
    check("no_conflict", 32'((ns_yellow | ns_green) & (ew_yellow | ew_green)), 32'(0));
    check("walk_vs_green", 32'(walk & (ns_green | ew_green)), 32'(0));
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic go(input int c);
    while (cyc < c) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("in_reset_lamps", 32'(dut_lamps), 32'(L_ALLRED));
    check("in_reset_ped", 32'(ped_pending), 32'(0));
    rst = 1'b0;
    cyc = 0;
    check("clr0", 32'(dut_lamps), 32'(L_ALLRED));

    // Free-running rotation with 16-cycle period
    go(1);  check("nsg1",  32'(dut_lamps), 32'(L_NSG));
    go(5);  check("nsg5",  32'(dut_lamps), 32'(L_NSG));
    go(6);  check("nsy6",  32'(dut_lamps), 32'(L_NSY));
    go(8);  check("clr8",  32'(dut_lamps), 32'(L_ALLRED));
    go(9);  check("ewg9",  32'(dut_lamps), 32'(L_EWG));
    go(14); check("ewy14", 32'(dut_lamps), 32'(L_EWY));
    go(16); check("clr16", 32'(dut_lamps), 32'(L_ALLRED));
    go(17); check("nsg17", 32'(dut_lamps), 32'(L_NSG));

    // Pedestrian pulse in 2nd NS green cycle
    go(18); ped_req = 1'b1;
    go(19); ped_req = 1'b0;
    check("ped_latched", 32'(ped_pending), 32'(1));
    go(21); check("nsg21_not_cut", 32'(dut_lamps), 32'(L_NSG));
    go(22); check("nsy22", 32'(dut_lamps), 32'(L_NSY));
    go(24); check("clr24", 32'(dut_lamps), 32'(L_ALLRED));
    go(25); check("walk25", 32'(dut_lamps), 32'(L_WALK));
    check("ped_cleared", 32'(ped_pending), 32'(0));
    go(27); check("walk27", 32'(dut_lamps), 32'(L_WALK));
    go(28); check("clr28", 32'(dut_lamps), 32'(L_ALLRED));
    go(29); check("ewg29", 32'(dut_lamps), 32'(L_EWG));

    // Emergency in 1st NS green cycle
    go(37); check("nsg37", 32'(dut_lamps), 32'(L_NSG));
    emerg = 1'b1;
    go(38); check("emg_nsy38", 32'(dut_lamps), 32'(L_NSY));
    go(39); check("emg_nsy39", 32'(dut_lamps), 32'(L_NSY));
    go(40); check("emg_clr40", 32'(dut_lamps), 32'(L_ALLRED));
    go(45); check("emg_hold45", 32'(dut_lamps), 32'(L_ALLRED));
    go(50); emerg = 1'b0;
    go(51); check("emg_clr51", 32'(dut_lamps), 32'(L_ALLRED));
    go(52); check("emg_ewg52", 32'(dut_lamps), 32'(L_EWG));

    // Walk, re-request on WALK entry, emergency in 2nd walk cycle
    go(60); check("nsg60", 32'(dut_lamps), 32'(L_NSG));
    ped_req = 1'b1;
    go(61); ped_req = 1'b0;
    go(68); check("walk68", 32'(dut_lamps), 32'(L_WALK));
    ped_req = 1'b1;
    go(69); ped_req = 1'b0;
    check("ped_set_wins", 32'(ped_pending), 32'(1));
    emerg = 1'b1;
    go(70); check("walk_dropped", 32'(walk), 32'(0));
    check("emg70", 32'(dut_lamps), 32'(L_ALLRED));
    emerg = 1'b0;
    go(71); check("clr71", 32'(dut_lamps), 32'(L_ALLRED));
    go(72); check("ped_first72", 32'(dut_lamps), 32'(L_WALK));
    check("ped_clr72", 32'(ped_pending), 32'(0));
    go(75); check("clr75", 32'(dut_lamps), 32'(L_ALLRED));
    go(76); check("ewg76", 32'(dut_lamps), 32'(L_EWG));

    // Asynchronous reset mid EW green
    go(77); ped_req = 1'b1;
    go(78); ped_req = 1'b0;
    check("ped_before_rst", 32'(ped_pending), 32'(1));
    check("ewg78", 32'(dut_lamps), 32'(L_EWG));
    #2 rst = 1'b1;
    #1;
    check("async_rst_lamps", 32'(dut_lamps), 32'(L_ALLRED));
    check("async_rst_ped", 32'(ped_pending), 32'(0));
    tick();
    tick();
    rst = 1'b0;
    cyc = 0;
    check("rst_clr0", 32'(dut_lamps), 32'(L_ALLRED));
    go(1); check("rst_nsg1", 32'(dut_lamps), 32'(L_NSG));
    go(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
